game_state_controller: RTL and testbench

//  Top-level game sequencer for the frog game. Consumes collision and level-up events

---
 rtl/game_state_controller_pkg.sv | 18 +
 rtl/game_state_controller_if.sv | 33 +++
 rtl/game_state_controller_freeze_timer.sv | 31 +++
 rtl/game_state_controller.sv | 130 +++++++++++++
 tb/tb_game_state_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared definitions for the frog game sequencer: state encoding and field widths.
// The HUD/score renderer reuses the lives/level widths from here.
package game_state_controller_pkg;

    localparam int unsigned c_LIVES_W = 3;
    localparam int unsigned c_LEVEL_W = 4;
    localparam int unsigned c_STATE_W = 3;
    localparam int unsigned c_TIMER_W = 25;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_DEATH = 3'b010,
        ST_LEVEL = 3'b011,
        ST_OVER  = 3'b100
    } state_t;

endpackage

// File: rtl/game_state_controller_if.sv
// Event/status bundle between the game sequencer and its neighbours.
//   i_Start        start button (debounced level)
//   i_Has_Collided frog/car overlap level
//   i_Level_Up     one-cycle top-row pulse
//   o_Game_Active  movement/scroll enable
//   o_Game_Over    high while in OVER
//   o_Lives        remaining lives
//   o_Level        current level (1-based)
//   o_State        state encoding for HUD/debug
interface game_state_controller_if;
    import game_state_controller_pkg::*;

    logic                 i_Start;
    logic                 i_Has_Collided;
    logic                 i_Level_Up;
    logic                 o_Game_Active;
    logic                 o_Game_Over;
    logic [c_LIVES_W-1:0] o_Lives;
    logic [c_LEVEL_W-1:0] o_Level;
    logic [c_STATE_W-1:0] o_State;

    // Side that drives events and observes status (datapath / bench).
    modport master (
        output i_Start, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_Game_Over, o_Lives, o_Level, o_State
    );

    // Sequencer side.
    modport slave (
        input  i_Start, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_Game_Over, o_Lives, o_Level, o_State
    );
endinterface

// File: rtl/game_state_controller_freeze_timer.sv
// Freeze-window down-counter.
//   i_Clk, i_Rst  clock, async active-high reset
//   i_Load        load i_Value into the counter
//   i_Value       load value (cycles - 1)
//   o_Expired     high while the count is zero
module game_state_controller_freeze_timer
    import game_state_controller_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Load,
    input  logic [c_TIMER_W-1:0] i_Value,
    output logic                 o_Expired
);

    logic [c_TIMER_W-1:0] r_Count;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= i_Value;
        end else if (r_Count != '0) begin
            r_Count <= r_Count - c_TIMER_W'(1);
        end
    end

    assign o_Expired = (r_Count == '0);

endmodule

// File: rtl/game_state_controller.sv
// Top-level frog game sequencer: start/collision/level-up handling, lives and
// level tracking, and timed freeze windows after a death or a level-up.
//   i_Clk   25 MHz pixel clock
//   i_Rst   async active-high reset
//   io_Bus  event inputs and registered status outputs (slave side)
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int unsigned c_LIVES_INI   = 3,
    parameter int unsigned c_MAX_LEVEL   = 15,
    parameter int unsigned DEATH_DELAY   = 25000000,
    parameter int unsigned LEVELUP_DELAY = 12500000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    game_state_controller_if.slave io_Bus
);

    state_t               r_State;
    logic                 r_Active;
    logic                 r_Over;
    logic [c_LIVES_W-1:0] r_Lives;
    logic [c_LEVEL_W-1:0] r_Level;
    logic                 r_Start_d;
    logic                 r_Coll_d;

    state_t               w_State_Next;
    logic                 w_Active_Next;
    logic                 w_Over_Next;
    logic [c_LIVES_W-1:0] w_Lives_Next;
    logic [c_LEVEL_W-1:0] w_Level_Next;
    logic                 w_Load;
    logic [c_TIMER_W-1:0] w_Load_Value;
    logic                 w_Expired;
    logic                 w_Start_Rise;
    logic                 w_Coll_Rise;

    assign w_Start_Rise = io_Bus.i_Start & ~r_Start_d;
    assign w_Coll_Rise  = io_Bus.i_Has_Collided & ~r_Coll_d;

    game_state_controller_freeze_timer u_freeze_timer (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Load    (w_Load),
        .i_Value   (w_Load_Value),
        .o_Expired (w_Expired)
    );

    // State, status and edge-detect registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State   <= ST_IDLE;
            r_Active  <= 1'b0;
            r_Over    <= 1'b0;
            r_Lives   <= '0;
            r_Level   <= c_LEVEL_W'(1);
            r_Start_d <= 1'b0;
            r_Coll_d  <= 1'b0;
        end else begin
            r_State   <= w_State_Next;
            r_Active  <= w_Active_Next;
            r_Over    <= w_Over_Next;
            r_Lives   <= w_Lives_Next;
            r_Level   <= w_Level_Next;
            r_Start_d <= io_Bus.i_Start;
            r_Coll_d  <= io_Bus.i_Has_Collided;
        end
    end

    // Next-state logic; a collision edge beats a simultaneous level-up.
    always_comb begin
        w_State_Next = r_State;
        case (r_State)
            ST_IDLE, ST_OVER: begin
                if (w_Start_Rise) w_State_Next = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_Coll_Rise)            w_State_Next = ST_DEATH;
                else if (io_Bus.i_Level_Up) w_State_Next = ST_LEVEL;
            end
            ST_DEATH: begin
                // Lives were already decremented on entry, so zero here means game over.
                if (w_Expired) w_State_Next = (r_Lives == '0) ? ST_OVER : ST_PLAY;
            end
            ST_LEVEL: begin
                if (w_Expired) w_State_Next = ST_PLAY;
            end
            default: w_State_Next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the timer load.
    always_comb begin
        w_Lives_Next  = r_Lives;
        w_Level_Next  = r_Level;
        w_Load        = 1'b0;
        w_Load_Value  = '0;
        w_Active_Next = (w_State_Next == ST_PLAY);
        w_Over_Next   = (w_State_Next == ST_OVER);
        case (r_State)
            ST_IDLE, ST_OVER: begin
                if (w_Start_Rise) begin
                    w_Lives_Next = c_LIVES_W'(c_LIVES_INI);
                    w_Level_Next = c_LEVEL_W'(1);
                end
            end
            ST_PLAY: begin
                if (w_Coll_Rise) begin
                    w_Lives_Next = r_Lives - c_LIVES_W'(1);
                    w_Load       = 1'b1;
                    w_Load_Value = c_TIMER_W'(DEATH_DELAY - 1);
                end else if (io_Bus.i_Level_Up) begin
                    if (r_Level < c_LEVEL_W'(c_MAX_LEVEL)) begin
                        w_Level_Next = r_Level + c_LEVEL_W'(1);
                    end
                    w_Load       = 1'b1;
                    w_Load_Value = c_TIMER_W'(LEVELUP_DELAY - 1);
                end
            end
            default: ;
        endcase
    end

    assign io_Bus.o_Game_Active = r_Active;
    assign io_Bus.o_Game_Over   = r_Over;
    assign io_Bus.o_Lives       = r_Lives;
    assign io_Bus.o_Level       = r_Level;
    assign io_Bus.o_State       = r_State;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller with short freeze delays and a level cap of 3.
module tb_game_state_controller;

    localparam int DD   = 8;
    localparam int LD   = 4;
    localparam int LINI = 3;
    localparam int LMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_state_controller_if bus ();

    game_state_controller #(
        .c_LIVES_INI   (LINI),
        .c_MAX_LEVEL   (LMAX),
        .DEATH_DELAY   (DD),
        .LEVELUP_DELAY (LD)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .io_Bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: mode 0=idle 1=play 2=death 3=level 4=over; rem = frozen cycles left.
    int m_mode, m_lives, m_level, m_rem;
    logic m_sd, m_cd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_lives <= 0; m_level <= 1; m_rem <= 0;
            m_sd <= 1'b0; m_cd <= 1'b0;
        end else begin
            m_sd <= bus.i_Start;
            m_cd <= bus.i_Has_Collided;
            case (m_mode)
                0, 4: if (bus.i_Start && !m_sd) begin
                    m_mode <= 1; m_lives <= LINI; m_level <= 1;
                end
                1: if (bus.i_Has_Collided && !m_cd) begin
                    m_mode <= 2; m_lives <= m_lives - 1; m_rem <= DD;
                end else if (bus.i_Level_Up) begin
                    m_mode <= 3; m_rem <= LD;
                    m_level <= (m_level + 1 > LMAX) ? LMAX : m_level + 1;
                end
                2: if (m_rem == 1) m_mode <= (m_lives == 0) ? 4 : 1;
                   else m_rem <= m_rem - 1;
                3: if (m_rem == 1) m_mode <= 1;
                   else m_rem <= m_rem - 1;
                default: m_mode <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("state",  int'(bus.o_State),       m_mode);
        chk("active", int'(bus.o_Game_Active), (m_mode == 1) ? 1 : 0);
        chk("over",   int'(bus.o_Game_Over),   (m_mode == 4) ? 1 : 0);
        chk("lives",  int'(bus.o_Lives),       m_lives);
        chk("level",  int'(bus.o_Level),       m_level);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Counts Active=0 cycles until back out of a freeze (bounded).
    task automatic wait_freeze(output int lows);
        int guard = 0;
        lows = 0;
        while ((bus.o_State == 3'd2 || bus.o_State == 3'd3) && guard < 40) begin
            if (!bus.o_Game_Active) lows++;
            step();
            guard++;
        end
        if (guard >= 40) chk("freeze_timeout", guard, 0);
    endtask

    task automatic collide(output int lows);
        bus.i_Has_Collided = 1'b1;
        step();
        bus.i_Has_Collided = 1'b0;
        wait_freeze(lows);
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        step();
        bus.i_Start = 1'b0;
    endtask

    int lows;
    int exp_lvl [4] = '{2, 3, 3, 3};

    initial begin
        bus.i_Start        = 1'b0;
        bus.i_Has_Collided = 1'b0;
        bus.i_Level_Up     = 1'b0;
        step(); step();
        chk("rst_state", int'(bus.o_State), 0);
        chk("rst_level", int'(bus.o_Level), 1);
        rst = 1'b0;
        step();

        // 1: start
        pulse_start();
        chk("t1_state", int'(bus.o_State), 1);
        chk("t1_active", int'(bus.o_Game_Active), 1);
        chk("t1_lives", int'(bus.o_Lives), 3);
        chk("t1_level", int'(bus.o_Level), 1);

        // 2: collision held 20 cycles counts once
        bus.i_Has_Collided = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.o_Game_Active) lows++;
        end
        bus.i_Has_Collided = 1'b0;
        step();
        chk("t2_lows", lows, 8);
        chk("t2_lives", int'(bus.o_Lives), 2);
        chk("t2_active", int'(bus.o_Game_Active), 1);

        // 3: run out of lives, then restart
        collide(lows);
        chk("t3_lows_a", lows, 8);
        collide(lows);
        chk("t3_state", int'(bus.o_State), 4);
        chk("t3_over", int'(bus.o_Game_Over), 1);
        chk("t3_lives", int'(bus.o_Lives), 0);
        chk("t3_active", int'(bus.o_Game_Active), 0);
        step(); step();
        chk("t3_held", int'(bus.o_State), 4);
        pulse_start();
        chk("t3_rs_state", int'(bus.o_State), 1);
        chk("t3_rs_lives", int'(bus.o_Lives), 3);
        chk("t3_rs_level", int'(bus.o_Level), 1);

        // 4: level-ups saturate at 3
        for (int k = 0; k < 4; k++) begin
            bus.i_Level_Up = 1'b1;
            step();
            bus.i_Level_Up = 1'b0;
            chk("t4_level", int'(bus.o_Level), exp_lvl[k]);
            wait_freeze(lows);
            chk("t4_lows", lows, 4);
            step();
        end

        // 5: simultaneous collision edge and level-up
        bus.i_Level_Up = 1'b1;
        bus.i_Has_Collided = 1'b1;
        step();
        bus.i_Level_Up = 1'b0;
        bus.i_Has_Collided = 1'b0;
        chk("t5_state", int'(bus.o_State), 2);
        chk("t5_lives", int'(bus.o_Lives), 2);
        chk("t5_level", int'(bus.o_Level), 3);
        wait_freeze(lows);
        chk("t5_lows", lows, 8);
        chk("t5_play", int'(bus.o_State), 1);

        // 6: async reset mid-death
        bus.i_Has_Collided = 1'b1;
        step();
        bus.i_Has_Collided = 1'b0;
        step(); step();
        chk("t6_pre", int'(bus.o_State), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_state", int'(bus.o_State), 0);
        chk("t6_active", int'(bus.o_Game_Active), 0);
        chk("t6_over", int'(bus.o_Game_Over), 0);
        chk("t6_lives", int'(bus.o_Lives), 0);
        chk("t6_level", int'(bus.o_Level), 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("t6_idle", int'(bus.o_State), 0);
        pulse_start();
        chk("t6_play", int'(bus.o_State), 1);
        chk("t6_lives_rl", int'(bus.o_Lives), 3);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
